// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one native memory-request port between the instruction
// fetch requester (imem) and the load/store requester (dmem).
//
// Each requester issues one-cycle request pulses. A pulse is captured into a
// per-port pending slot. The arbiter picks one candidate and forwards it to the
// bridge as a one-cycle mem_valid pulse. It then routes the single bridge
// completion back to the owner in the same cycle.
//
// Parameters:
//   PRIORITY   0 = round-robin on ties, 1 = dmem always wins ties
// Ports:
//   clock, reset              system clock, synchronous active-low reset
//   imem_valid/addr           fetch request pulse and byte address
//   imem_rdata/ready          fetch completion (combinational route of mem_*)
//   dmem_valid/addr/wdata/wstrb  data request pulse; wstrb==0 means load
//   dmem_rdata/ready          data completion (combinational route of mem_*)
//   mem_valid/instr/addr/wdata/wstrb  registered request to the bridge
//   mem_rdata/ready           bridge response
module mem_arbiter #(
    parameter int PRIORITY = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    // Pending slots, one per requester.
    logic        i_full_r;
    logic [31:0] i_addr_r;
    logic        d_full_r;
    logic [31:0] d_addr_r;
    logic [31:0] d_wdata_r;
    logic [3:0]  d_wstrb_r;

    // 1 when the most recent grant went to dmem.
    logic        last_d_r;

    // Registered request towards the bridge.
    logic        mem_valid_r;
    logic        mem_instr_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [3:0]  mem_wstrb_r;

    // Candidate view: a same-cycle pulse takes precedence over the slot contents.
    logic        i_cand_s;
    logic        d_cand_s;
    logic [31:0] i_cand_addr_s;
    logic [31:0] d_cand_addr_s;
    logic [31:0] d_cand_wdata_s;
    logic [3:0]  d_cand_wstrb_s;
    logic        grant_d_s;
    logic        sel_open_s;
    logic        issue_s;

    logic        imem_ready_s;
    logic        dmem_ready_s;
    logic [31:0] imem_rdata_s;
    logic [31:0] dmem_rdata_s;

    // Candidate gathering and tie-break between the two ports.
    always_comb begin
        i_cand_s = imem_valid | i_full_r;
        d_cand_s = dmem_valid | d_full_r;
        if (imem_valid) begin
            i_cand_addr_s = imem_addr;
        end else begin
            i_cand_addr_s = i_addr_r;
        end
        if (dmem_valid) begin
            d_cand_addr_s  = dmem_addr;
            d_cand_wdata_s = dmem_wdata;
            d_cand_wstrb_s = dmem_wstrb;
        end else begin
            d_cand_addr_s  = d_addr_r;
            d_cand_wdata_s = d_wdata_r;
            d_cand_wstrb_s = d_wstrb_r;
        end
        if (i_cand_s && d_cand_s) begin
            if (PRIORITY == 1) begin
                grant_d_s = 1'b1;
            end else begin
                grant_d_s = ~last_d_r;
            end
        end else begin
            grant_d_s = d_cand_s;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic. Selection is open in IDLE or on the completion cycle.
    always_comb begin
        sel_open_s   = 1'b0;
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE:   sel_open_s = 1'b1;
            ST_BUSY_I: sel_open_s = mem_ready;
            ST_BUSY_D: sel_open_s = mem_ready;
            // An unreachable encoding behaves as IDLE so the FSM recovers.
            default:   sel_open_s = 1'b1;
        endcase
        issue_s = sel_open_s & (i_cand_s | d_cand_s);
        if (issue_s) begin
            if (grant_d_s) begin
                state_next_s = ST_BUSY_D;
            end else begin
                state_next_s = ST_BUSY_I;
            end
        end else if (sel_open_s) begin
            state_next_s = ST_IDLE;
        end else begin
            state_next_s = state_r;
        end
    end

    // Output logic: route the bridge completion to the owner named by the state.
    always_comb begin
        imem_ready_s = 1'b0;
        dmem_ready_s = 1'b0;
        imem_rdata_s = 32'h0000_0000;
        dmem_rdata_s = 32'h0000_0000;
        case (state_r)
            ST_BUSY_I: begin
                if (mem_ready) begin
                    imem_ready_s = 1'b1;
                    imem_rdata_s = mem_rdata;
                end else begin
                    imem_ready_s = 1'b0;
                    imem_rdata_s = 32'h0000_0000;
                end
            end
            ST_BUSY_D: begin
                if (mem_ready) begin
                    dmem_ready_s = 1'b1;
                    dmem_rdata_s = mem_rdata;
                end else begin
                    dmem_ready_s = 1'b0;
                    dmem_rdata_s = 32'h0000_0000;
                end
            end
            default: begin
                imem_ready_s = 1'b0;
                dmem_ready_s = 1'b0;
            end
        endcase
    end

    // Bridge request register. The payload holds while the bridge is busy.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_valid_r <= 1'b0;
            mem_instr_r <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_wstrb_r <= 4'h0;
        end else if (issue_s) begin
            mem_valid_r <= 1'b1;
            if (grant_d_s) begin
                mem_instr_r <= 1'b0;
                mem_addr_r  <= d_cand_addr_s;
                mem_wdata_r <= d_cand_wdata_s;
                mem_wstrb_r <= d_cand_wstrb_s;
            end else begin
                mem_instr_r <= 1'b1;
                mem_addr_r  <= i_cand_addr_s;
                mem_wdata_r <= 32'h0000_0000;
                mem_wstrb_r <= 4'h0;
            end
        end else begin
            mem_valid_r <= 1'b0;
        end
    end

    // Grant history used for the round-robin tie-break.
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_d_r <= 1'b0;
        end else if (issue_s) begin
            last_d_r <= grant_d_s;
        end else begin
            last_d_r <= last_d_r;
        end
    end

    // imem pending slot. Issuing clears it. A same-cycle pulse was the issued value.
    always_ff @(posedge clock) begin
        if (!reset) begin
            i_full_r <= 1'b0;
            i_addr_r <= 32'h0000_0000;
        end else if (issue_s && !grant_d_s) begin
            i_full_r <= 1'b0;
        end else if (imem_valid) begin
            i_full_r <= 1'b1;
            i_addr_r <= imem_addr;
        end else begin
            i_full_r <= i_full_r;
        end
    end

    // dmem pending slot, same policy as the imem slot.
    always_ff @(posedge clock) begin
        if (!reset) begin
            d_full_r  <= 1'b0;
            d_addr_r  <= 32'h0000_0000;
            d_wdata_r <= 32'h0000_0000;
            d_wstrb_r <= 4'h0;
        end else if (issue_s && grant_d_s) begin
            d_full_r <= 1'b0;
        end else if (dmem_valid) begin
            d_full_r  <= 1'b1;
            d_addr_r  <= dmem_addr;
            d_wdata_r <= dmem_wdata;
            d_wstrb_r <= dmem_wstrb;
        end else begin
            d_full_r <= d_full_r;
        end
    end

    assign mem_valid  = mem_valid_r;
    assign mem_instr  = mem_instr_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_wstrb  = mem_wstrb_r;
    assign imem_ready = imem_ready_s;
    assign dmem_ready = dmem_ready_s;
    assign imem_rdata = imem_rdata_s;
    assign dmem_rdata = dmem_rdata_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives two arbiters (PRIORITY=0 and PRIORITY=1) with identical
// inputs. Every output is compared each cycle against a transaction-level
// reference model of the arbitration rules. The inputs are a few directed
// scenarios followed by randomized traffic with occasional resets.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    wire [1:0]        o_imem_ready;
    wire [1:0]        o_dmem_ready;
    wire [1:0][31:0]  o_imem_rdata;
    wire [1:0][31:0]  o_dmem_rdata;
    wire [1:0]        o_mem_valid;
    wire [1:0]        o_mem_instr;
    wire [1:0][31:0]  o_mem_addr;
    wire [1:0][31:0]  o_mem_wdata;
    wire [1:0][3:0]   o_mem_wstrb;

    always #5 clock = ~clock;

    mem_arbiter #(.PRIORITY(0)) dut_rr (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_addr(imem_addr),
        .imem_rdata(o_imem_rdata[0]), .imem_ready(o_imem_ready[0]),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(o_dmem_rdata[0]), .dmem_ready(o_dmem_ready[0]),
        .mem_valid(o_mem_valid[0]), .mem_instr(o_mem_instr[0]),
        .mem_addr(o_mem_addr[0]), .mem_wdata(o_mem_wdata[0]),
        .mem_wstrb(o_mem_wstrb[0]),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    mem_arbiter #(.PRIORITY(1)) dut_fx (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_addr(imem_addr),
        .imem_rdata(o_imem_rdata[1]), .imem_ready(o_imem_ready[1]),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(o_dmem_rdata[1]), .dmem_ready(o_dmem_ready[1]),
        .mem_valid(o_mem_valid[1]), .mem_instr(o_mem_instr[1]),
        .mem_addr(o_mem_addr[1]), .mem_wdata(o_mem_wdata[1]),
        .mem_wstrb(o_mem_wstrb[1]),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    // Reference model state per instance; index = PRIORITY value.
    int          owner   [2];   // 0 none, 1 imem in flight, 2 dmem in flight
    bit          pend_i  [2];
    bit          pend_d  [2];
    logic [31:0] pi_addr [2];
    logic [31:0] pd_addr [2];
    logic [31:0] pd_wdata[2];
    logic [3:0]  pd_wstrb[2];
    bit          last_d  [2];
    bit          e_mv    [2];
    bit          e_mi    [2];
    logic [31:0] e_ma    [2];
    logic [31:0] e_mw    [2];
    logic [3:0]  e_ms    [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model of instance k by one clock edge using the current inputs.
    task automatic model_step(input int k);
        bit open;
        bit ci;
        bit cd;
        bit pick_d;
        if (!reset) begin
            owner[k] = 0; pend_i[k] = 1'b0; pend_d[k] = 1'b0; last_d[k] = 1'b0;
            e_mv[k] = 1'b0; e_mi[k] = 1'b0;
            e_ma[k] = 32'h0; e_mw[k] = 32'h0; e_ms[k] = 4'h0;
        end else begin
            open = (owner[k] == 0) || mem_ready;
            ci = imem_valid || pend_i[k];
            cd = dmem_valid || pend_d[k];
            if (imem_valid) pi_addr[k] = imem_addr;
            if (dmem_valid) begin
                pd_addr[k] = dmem_addr; pd_wdata[k] = dmem_wdata; pd_wstrb[k] = dmem_wstrb;
            end
            if (imem_valid) pend_i[k] = 1'b1;
            if (dmem_valid) pend_d[k] = 1'b1;
            if (open && (ci || cd)) begin
                pick_d = cd && (!ci || k == 1 || !last_d[k]);
                e_mv[k] = 1'b1;
                last_d[k] = pick_d;
                if (pick_d) begin
                    owner[k] = 2; pend_d[k] = 1'b0; e_mi[k] = 1'b0;
                    e_ma[k] = pd_addr[k]; e_mw[k] = pd_wdata[k]; e_ms[k] = pd_wstrb[k];
                end else begin
                    owner[k] = 1; pend_i[k] = 1'b0; e_mi[k] = 1'b1;
                    e_ma[k] = pi_addr[k]; e_mw[k] = 32'h0; e_ms[k] = 4'h0;
                end
            end else begin
                e_mv[k] = 1'b0;
                if (open) owner[k] = 0;
            end
        end
    endtask

    // One clock cycle: apply inputs, compare every output of both instances, step the models.
    task automatic cyc(input bit rv, input bit iv, input logic [31:0] ia,
                       input bit dv, input logic [31:0] da, input logic [31:0] dw,
                       input logic [3:0] ds, input bit mr, input logic [31:0] md);
        logic ir;
        logic dr;
        @(negedge clock);
        reset = rv; imem_valid = iv; imem_addr = ia;
        dmem_valid = dv; dmem_addr = da; dmem_wdata = dw; dmem_wstrb = ds;
        mem_ready = mr; mem_rdata = md;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (checking) begin
                ir = (owner[k] == 1) && mem_ready;
                dr = (owner[k] == 2) && mem_ready;
                check($sformatf("p%0d_imem_ready", k), 32'(o_imem_ready[k]), 32'(ir));
                check($sformatf("p%0d_imem_rdata", k), o_imem_rdata[k], ir ? mem_rdata : 32'h0);
                check($sformatf("p%0d_dmem_ready", k), 32'(o_dmem_ready[k]), 32'(dr));
                check($sformatf("p%0d_dmem_rdata", k), o_dmem_rdata[k], dr ? mem_rdata : 32'h0);
                check($sformatf("p%0d_mem_valid", k), 32'(o_mem_valid[k]), 32'(e_mv[k]));
                check($sformatf("p%0d_mem_instr", k), 32'(o_mem_instr[k]), 32'(e_mi[k]));
                check($sformatf("p%0d_mem_addr", k), o_mem_addr[k], e_ma[k]);
                check($sformatf("p%0d_mem_wdata", k), o_mem_wdata[k], e_mw[k]);
                check($sformatf("p%0d_mem_wstrb", k), 32'(o_mem_wstrb[k]), 32'(e_ms[k]));
            end
            model_step(k);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic done(input logic [31:0] md);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, md);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    endtask

    initial begin
        reset = 1'b0; imem_valid = 1'b0; imem_addr = 32'h0; dmem_valid = 1'b0;
        dmem_addr = 32'h0; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        do_reset(1);
        checking = 1'b1;
        do_reset(1);

        // Single fetch, completed four cycles after the request pulse.
        cyc(1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        idle(3);
        done(32'hDEAD_BEEF);
        idle(2);

        // Simultaneous requests right after reset.
        do_reset(1);
        cyc(1'b1, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 1'b0, 32'h0);
        idle(2);
        done(32'hA5A5_0001);
        idle(1);
        done(32'hA5A5_0002);
        done(32'hA5A5_0003);
        idle(1);

        // Both ports re-request on every completion.
        do_reset(1);
        cyc(1'b1, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_3000, 32'h0000_0055, 4'h3, 1'b0, 32'h0);
        for (int t = 0; t < 6; t++) begin
            idle(1);
            cyc(1'b1, 1'b1, 32'h0000_0400 + 32'(t * 4), 1'b1, 32'h0000_3000 + 32'(t * 4),
                32'(t), 4'h3, 1'b1, 32'h0000_7000 + 32'(t));
        end
        idle(1);
        done(32'h0000_0BAD);
        done(32'h0000_0BAE);
        idle(1);

        // Load pulses while a fetch is in flight, then waits in its slot.
        cyc(1'b1, 1'b1, 32'h0000_0500, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_2000, 32'h0, 4'h0, 1'b0, 32'h0);
        idle(1);
        done(32'h1111_2222);
        idle(1);
        done(32'h3333_4444);
        idle(1);

        // Fetch pulse arriving on the completion cycle of a store.
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_2400, 32'hCAFE_F00D, 4'h5, 1'b0, 32'h0);
        idle(1);
        cyc(1'b1, 1'b1, 32'h0000_0600, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h5555_6666);
        idle(1);
        done(32'h7777_8888);
        idle(1);

        // Reset while a data access is in flight and a fetch is pending.
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_2800, 32'h0, 4'h0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h0000_0700, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        do_reset(1);
        idle(3);
        done(32'h9999_AAAA);
        idle(2);

        // Randomized traffic, including protocol-tolerated overwrites and stray readies.
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(299) != 0,
                $urandom_range(3) == 0, $urandom,
                $urandom_range(3) == 0, $urandom, $urandom,
                ($urandom_range(2) == 0) ? 4'h0 : 4'($urandom),
                $urandom_range(2) == 0, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter sharing one native memory-request port between the instruction-fetch requester (imem) and the load/store requester (dmem).
- Sits in front of the AXI4 master bridge; drives its valid/instr/addr/wdata/wstrb request and consumes its rdata/ready response.
- Captures one-cycle request pulses from each port, selects one, forwards it as a one-cycle pulse and routes the single response back to the owner.

Parameters:
- PRIORITY, 0, tie-break policy: 0 = round-robin between ports; 1 = fixed, dmem always wins ties.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- imem_valid  in  1  one-cycle instruction-fetch request pulse
- imem_addr  in  32  fetch byte address
- imem_rdata  out  32  fetch read data, valid when imem_ready=1
- imem_ready  out  1  one-cycle fetch completion pulse
- dmem_valid  in  1  one-cycle data request pulse
- dmem_addr  in  32  data byte address
- dmem_wdata  in  32  store data
- dmem_wstrb  in  4  byte strobes; 0 = load, nonzero = store
- dmem_rdata  out  32  load data, valid when dmem_ready=1
- dmem_ready  out  1  one-cycle data completion pulse (loads and stores)
- mem_valid  out  1  one-cycle request pulse to bridge
- mem_instr  out  1  1 = instruction fetch, 0 = data access
- mem_addr  out  32  forwarded address
- mem_wdata  out  32  forwarded store data; 0 for fetches
- mem_wstrb  out  4  forwarded strobes; 0 for fetches
- mem_rdata  in  32  bridge read data
- mem_ready  in  1  bridge completion pulse

Behaviour:
- Reset (reset==0 at posedge clock): state=IDLE; both pending slots empty; last_grant=imem.
  - All mem_* outputs 0; imem_ready=dmem_ready=0 and both rdata outputs=0.
- Pending slots: one slot per port, holding addr (plus wdata/wstrb for dmem).
  - A slot is set on any cycle its valid=1, regardless of state.
  - A slot is cleared on the cycle its request is issued.
  - A new valid to an already-full slot overwrites it; requesters must not issue a second request before ready.
- Candidates each selection cycle: full slots plus same-cycle valid inputs.
- Selection rule:
  - Only one candidate: that candidate wins.
  - Both candidates, PRIORITY=0: the port not equal to last_grant wins.
  - Both candidates, PRIORITY=1: dmem wins.
  - Winner updates last_grant.
- States: IDLE, BUSY_I, BUSY_D.
  - IDLE with a candidate: register the winner onto mem_* with mem_valid=1 for exactly the next cycle; go BUSY_I or BUSY_D.
  - BUSY_x, mem_ready=0: mem_valid=0; mem_addr, mem_wdata, mem_wstrb and mem_instr hold their values.
  - BUSY_x, mem_ready=1: x_ready=1 and x_rdata=mem_rdata in the same cycle (combinational route, owner taken from state).
    - Other port's ready stays 0 and its rdata stays 0.
    - Same cycle, run selection; with a candidate, issue it next cycle (back-to-back, no IDLE bubble) and enter the matching BUSY; otherwise go IDLE.
- Latency:
  - Request pulse at cycle t in IDLE -> mem_valid=1 at t+1.
  - mem_ready at cycle r -> requester ready at r.
  - Next queued request -> mem_valid at r+1.
- mem_instr=1 only for imem grants; fetches force mem_wstrb=0 and mem_wdata=0.
- mem_ready while IDLE is ignored; no ready output asserts.
- Reset mid-transaction drops the in-flight and pending requests; the bridge is reset by the same signal.

Test Plan:
- Single fetch: imem_valid=1, addr=0x00000100 at t.
  - mem_valid=1, mem_instr=1, mem_addr=0x100, mem_wstrb=0 at t+1.
  - mem_ready=1, mem_rdata=0xDEADBEEF at t+4 -> imem_ready=1, imem_rdata=0xDEADBEEF at t+4; dmem_ready=0.
- Simultaneous requests right after reset, PRIORITY=0: imem addr 0x200 and dmem store addr 0x1000, wdata=0x12345678, wstrb=0xF.
  - dmem issued first.
  - On its mem_ready: dmem_ready=1; imem request (mem_instr=1, addr 0x200) issued the next cycle.
- Round-robin fairness: both ports re-request on every completion for 6 transactions.
  - mem_instr alternates 0,1,0,1,0,1.
  - Repeat with PRIORITY=1: dmem re-requests always win.
- Request during busy: dmem load 0x2000 (wstrb=0) pulses while BUSY_I.
  - Held in slot, issued cycle after imem completion.
  - dmem_rdata equals mem_rdata on its own ready; imem_ready never asserts for it.
- Same-cycle arrival with completion: imem_valid pulses in the cycle mem_ready=1 for a dmem request.
  - dmem_ready=1 that cycle; mem_valid=1 with addr=imem_addr the next cycle.
- Reset mid-operation: reset=0 during BUSY_D with an imem request pending.
  - All outputs 0 next cycle; after release no mem_valid until a new request arrives.
